// File: rtl/vdp_sprite_meta_pkg.sv
// Shared constants, types and helpers for the sprite metadata write scheduler.
package vdp_sprite_meta_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned SPRITE_W         = 8;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned SEL_W            = 3;
  localparam int unsigned COUNT_W          = 9;
  localparam int unsigned WORD_W           = 2;
  localparam int unsigned WORDS_PER_SPRITE = 3;

  // DMA sequencer states
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  // One-hot metadata block selects
  localparam logic [SEL_W-1:0] BLOCK_X = 3'b001;
  localparam logic [SEL_W-1:0] BLOCK_Y = 3'b010;
  localparam logic [SEL_W-1:0] BLOCK_G = 3'b100;

  // One write into the sprite core's metadata port
  typedef struct packed {
    logic [SPRITE_W-1:0] address;
    logic [SEL_W-1:0]    block_select;
    logic [DATA_W-1:0]   data;
  } meta_wr_t;

  // Word position within a sprite's x/y/g triple -> block select
  function automatic logic [SEL_W-1:0] word_to_block(input logic [WORD_W-1:0] w);
    logic [SEL_W-1:0] sel;
    case (w)
      2'd0:    sel = BLOCK_X;
      2'd1:    sel = BLOCK_Y;
      2'd2:    sel = BLOCK_G;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vdp_sprite_meta_arbiter.sv
// Two-requester mux onto the sprite core metadata port, with the output register.
module vdp_sprite_meta_arbiter
  import vdp_sprite_meta_pkg::*;
#(
  parameter int unsigned HOST_PRIORITY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                host_req,
  input  meta_wr_t            host_wr,
  input  logic                dma_req,
  input  meta_wr_t            dma_wr,
  output logic                host_ready_c,
  output logic                dma_grant_c,
  output logic [SPRITE_W-1:0] meta_address,
  output logic [DATA_W-1:0]   meta_write_data,
  output logic [SEL_W-1:0]    meta_block_select,
  output logic                meta_we
);

  logic     host_take_c;
  logic     meta_we_d, meta_we_q;
  meta_wr_t meta_d, meta_q;

  // Grant decision; host writes arriving while in reset are dropped
  always_comb begin
    host_ready_c = 1'b0;
    dma_grant_c  = 1'b0;
    if (HOST_PRIORITY != 0) begin
      host_ready_c = reset_n;
      dma_grant_c  = dma_req & ~host_req;
    end else begin
      host_ready_c = reset_n & ~dma_req;
      dma_grant_c  = dma_req;
    end
    host_take_c = host_req & host_ready_c;
  end

  // Next output payload; the port holds its last value when idle
  always_comb begin
    meta_we_d = host_take_c | dma_grant_c;
    meta_d    = meta_q;
    if (host_take_c) begin
      meta_d = host_wr;
    end else if (dma_grant_c) begin
      meta_d = dma_wr;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_we_q <= 1'b0;
      meta_q    <= '0;
    end else begin
      meta_we_q <= meta_we_d;
      meta_q    <= meta_d;
    end
  end

  assign meta_we           = meta_we_q;
  assign meta_address      = meta_q.address;
  assign meta_block_select = meta_q.block_select;
  assign meta_write_data   = meta_q.data;

endmodule

// File: rtl/vdp_sprite_meta_scheduler.sv
// Sequences host writes and sprite-attribute DMA onto the single metadata write port.
module vdp_sprite_meta_scheduler
  import vdp_sprite_meta_pkg::*;
#(
  parameter int unsigned SRC_ADDR_WIDTH = 16,
  parameter int unsigned HOST_PRIORITY  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      host_we,
  input  logic [SPRITE_W-1:0]       host_address,
  input  logic [SEL_W-1:0]          host_block_select,
  input  logic [DATA_W-1:0]         host_write_data,
  output logic                      host_ready,
  input  logic                      dma_start,
  input  logic [SRC_ADDR_WIDTH-1:0] dma_src_address,
  input  logic [SPRITE_W-1:0]       dma_first_sprite,
  input  logic [COUNT_W-1:0]        dma_count,
  input  logic                      dma_allowed,
  output logic                      dma_busy,
  output logic                      dma_done,
  output logic [SRC_ADDR_WIDTH-1:0] src_read_address,
  output logic                      src_read_req,
  input  logic [DATA_W-1:0]         src_read_data,
  input  logic                      src_read_valid,
  output logic [SPRITE_W-1:0]       meta_address,
  output logic [DATA_W-1:0]         meta_write_data,
  output logic [SEL_W-1:0]          meta_block_select,
  output logic                      meta_we
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_SPRITE - 1);

  logic [STATE_W-1:0]        state_d, state_q;
  logic [SRC_ADDR_WIDTH-1:0] src_ptr_d, src_ptr_q;
  logic [SPRITE_W-1:0]       sprite_d, sprite_q;
  logic [COUNT_W-1:0]        remain_d, remain_q;
  logic [WORD_W-1:0]         word_d, word_q;
  logic [DATA_W-1:0]         hold_d, hold_q;
  logic                      busy_d, busy_q;
  logic                      done_d, done_q;
  logic                      req_d, req_q;

  logic     dma_req_c;
  logic     dma_grant_c;
  logic     host_ready_c;
  meta_wr_t host_wr_c;
  meta_wr_t dma_wr_c;

  // Port request payloads
  always_comb begin
    dma_req_c = (state_q == ST_WRITE) & dma_allowed;
    host_wr_c = '{address: host_address, block_select: host_block_select, data: host_write_data};
    dma_wr_c  = '{address: sprite_q, block_select: word_to_block(word_q), data: hold_q};
  end

  vdp_sprite_meta_arbiter #(
    .HOST_PRIORITY(HOST_PRIORITY)
  ) u_arbiter (
    .clk              (clk),
    .reset_n          (reset_n),
    .host_req         (host_we),
    .host_wr          (host_wr_c),
    .dma_req          (dma_req_c),
    .dma_wr           (dma_wr_c),
    .host_ready_c     (host_ready_c),
    .dma_grant_c      (dma_grant_c),
    .meta_address     (meta_address),
    .meta_write_data  (meta_write_data),
    .meta_block_select(meta_block_select),
    .meta_we          (meta_we)
  );

  // DMA sequencer next state, counters and registered status outputs
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    sprite_d  = sprite_q;
    remain_d  = remain_q;
    word_d    = word_q;
    hold_d    = hold_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          if (dma_count == '0) begin
            done_d = 1'b1;
          end else begin
            src_ptr_d = dma_src_address;
            sprite_d  = dma_first_sprite;
            remain_d  = dma_count;
            word_d    = '0;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (src_read_valid) begin
          hold_d  = src_read_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (dma_grant_c) begin
          src_ptr_d = src_ptr_q + SRC_ADDR_WIDTH'(1);
          if (word_q != LAST_WORD) begin
            word_d  = word_q + WORD_W'(1);
            state_d = ST_REQ;
          end else if (remain_q > COUNT_W'(1)) begin
            word_d   = '0;
            sprite_d = sprite_q + SPRITE_W'(1);
            remain_d = remain_q - COUNT_W'(1);
            state_d  = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flops follow the state being entered so they line up with it
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ) | (state_d == ST_WAIT) | (state_d == ST_WRITE);
    done_d = done_d | (state_d == ST_DONE);
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      sprite_q  <= '0;
      remain_q  <= '0;
      word_q    <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      sprite_q  <= sprite_d;
      remain_q  <= remain_d;
      word_q    <= word_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
    end
  end

  assign host_ready       = host_ready_c;
  assign dma_busy         = busy_q;
  assign dma_done         = done_q;
  assign src_read_req     = req_q;
  assign src_read_address = src_ptr_q;

endmodule

// File: tb/tb_vdp_sprite_meta_scheduler.sv
// Randomized self-checking bench for the sprite metadata write scheduler.
module tb_vdp_sprite_meta_scheduler;

  logic        clk;
  logic        reset_n;
  logic        host_we;
  logic [7:0]  host_address;
  logic [2:0]  host_block_select;
  logic [15:0] host_write_data;
  logic        host_ready;
  logic        dma_start;
  logic [15:0] dma_src_address;
  logic [7:0]  dma_first_sprite;
  logic [8:0]  dma_count;
  logic        dma_allowed;
  logic        dma_busy;
  logic        dma_done;
  logic [15:0] src_read_address;
  logic        src_read_req;
  logic [15:0] src_read_data;
  logic        src_read_valid;
  logic [7:0]  meta_address;
  logic [15:0] meta_write_data;
  logic [2:0]  meta_block_select;
  logic        meta_we;

  vdp_sprite_meta_scheduler #(
    .SRC_ADDR_WIDTH(16),
    .HOST_PRIORITY (1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .host_we          (host_we),
    .host_address     (host_address),
    .host_block_select(host_block_select),
    .host_write_data  (host_write_data),
    .host_ready       (host_ready),
    .dma_start        (dma_start),
    .dma_src_address  (dma_src_address),
    .dma_first_sprite (dma_first_sprite),
    .dma_count        (dma_count),
    .dma_allowed      (dma_allowed),
    .dma_busy         (dma_busy),
    .dma_done         (dma_done),
    .src_read_address (src_read_address),
    .src_read_req     (src_read_req),
    .src_read_data    (src_read_data),
    .src_read_valid   (src_read_valid),
    .meta_address     (meta_address),
    .meta_write_data  (meta_write_data),
    .meta_block_select(meta_block_select),
    .meta_we          (meta_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source memory contents as a pure function of the address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 16'd40503) ^ 16'h5A3C;
  endfunction

  // Reference model state: pending DMA writes {sprite, select, data} and source reads
  logic [26:0] dma_q[$];
  logic [15:0] src_q[$];
  int          done_cnt = 0;
  int          dma_seen = 0;
  int          src_lat  = 2;
  logic [26:0] last_meta = '0;

  // Inputs as sampled by the DUT at the active edge
  logic        p_rst = 1'b0;
  logic        p_host_we = 1'b0;
  logic [26:0] p_host_wr = '0;
  logic        p_allowed = 1'b0;

  always @(posedge clk) begin
    p_rst     = reset_n;
    p_host_we = host_we;
    p_host_wr = {host_address, host_block_select, host_write_data};
    p_allowed = dma_allowed;
  end

  // Port monitor: host writes land one cycle later, everything else must be the next DMA word
  always @(negedge clk) begin
    logic [26:0] obs;
    obs = {meta_address, meta_block_select, meta_write_data};
    if (!p_rst) begin
      chk("reset_outs", {meta_we, obs, dma_busy, dma_done, src_read_req, src_read_address},
          64'd0);
      last_meta = '0;
    end else begin
      if (p_host_we) begin
        chk("host_we", 64'(meta_we), 64'd1);
        chk("host_wr", 64'(obs), 64'(p_host_wr));
        last_meta = obs;
      end else if (meta_we) begin
        if (dma_q.size() == 0) begin
          chk("dma_unexpected", 64'(meta_we), 64'd0);
        end else begin
          chk("dma_gate", 64'(p_allowed), 64'd1);
          chk("dma_wr", 64'(obs), 64'(dma_q.pop_front()));
          dma_seen++;
        end
        last_meta = obs;
      end else begin
        chk("meta_hold", 64'(obs), 64'(last_meta));
      end
      if (dma_done) begin
        done_cnt++;
        chk("done_busy", 64'(dma_busy), 64'd0);
      end
    end
  end

  // Source memory responder: one outstanding read, fixed latency per test
  int          pend_cnt = 0;
  logic [15:0] pend_addr = '0;

  always @(negedge clk) begin
    src_read_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        src_read_valid = 1'b1;
        src_read_data  = mem_word(pend_addr);
      end
    end
    if (src_read_req) begin
      if (src_q.size() == 0) begin
        chk("src_unexpected", 64'(src_read_req), 64'd0);
      end else begin
        chk("src_addr", 64'(src_read_address), 64'(src_q.pop_front()));
      end
      pend_cnt  = src_lat;
      pend_addr = src_read_address;
    end
  end

  // Expected words of a transfer, straight from the x/y/g source layout
  task automatic build_expect(input logic [15:0] src, input logic [7:0] first, input int cnt);
    logic [15:0] a;
    logic [7:0]  spr;
    logic [2:0]  sel;
    for (int s = 0; s < cnt; s++) begin
      for (int w = 0; w < 3; w++) begin
        a   = 16'(src + 16'(3 * s + w));
        spr = 8'(first + 8'(s));
        sel = 3'(1 << w);
        src_q.push_back(a);
        dma_q.push_back({spr, sel, mem_word(a)});
      end
    end
  endtask

  // mode 0: always allowed, 1: random gaps, 2: 20-cycle hold after two words
  task automatic run_dma(input logic [15:0] src, input logic [7:0] first, input int cnt,
                         input int mode, input int host_pct, input int lat);
    int base_done;
    int base_seen;
    int cyc;
    int gate_left;
    bit gated;
    src_lat   = lat;
    build_expect(src, first, cnt);
    base_done = done_cnt;
    base_seen = dma_seen;
    gate_left = 0;
    gated     = 1'b0;
    @(negedge clk);
    dma_src_address  = src;
    dma_first_sprite = first;
    dma_count        = 9'(cnt);
    dma_start        = 1'b1;
    dma_allowed      = (mode != 1) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
    @(negedge clk);
    dma_start = 1'b0;
    chk("busy_start", 64'(dma_busy), 64'd1);
    cyc = 0;
    while (done_cnt == base_done && cyc < 20000) begin
      host_we           = 1'(($urandom_range(0, 99) < host_pct));
      host_address      = 8'($urandom);
      host_block_select = 3'($urandom);
      host_write_data   = 16'($urandom);
      case (mode)
        1: dma_allowed = 1'(($urandom_range(0, 3) != 0));
        2: begin
          if (!gated && (dma_seen - base_seen) >= 2) begin
            gated     = 1'b1;
            gate_left = 20;
          end
          dma_allowed = (gate_left == 0);
          if (gate_left > 0) gate_left--;
        end
        default: dma_allowed = 1'b1;
      endcase
      @(negedge clk);
      cyc++;
    end
    host_we     = 1'b0;
    dma_allowed = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt - base_done), 64'd1);
    chk("dma_left", 64'(dma_q.size()), 64'd0);
    chk("src_left", 64'(src_q.size()), 64'd0);
    chk("busy_after", 64'(dma_busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int base_done;
    reset_n           = 1'b0;
    host_we           = 1'b0;
    host_address      = '0;
    host_block_select = '0;
    host_write_data   = '0;
    dma_start         = 1'b0;
    dma_src_address   = '0;
    dma_first_sprite  = '0;
    dma_count         = '0;
    dma_allowed       = 1'b0;
    src_read_data     = '0;
    src_read_valid    = 1'b0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed host write
    host_we           = 1'b1;
    host_address      = 8'h05;
    host_block_select = 3'b010;
    host_write_data   = 16'h1234;
    #1 chk("host_ready", 64'(host_ready), 64'd1);
    @(negedge clk);
    host_we = 1'b0;
    chk("host_direct", {meta_we, meta_address, meta_block_select, meta_write_data},
        {1'b1, 8'h05, 3'b010, 16'h1234});
    @(negedge clk);
    chk("host_we_drop", 64'(meta_we), 64'd0);

    // Directed transfers: plain, wrap, host conflicts, gating, full 256 sprites
    run_dma(16'h0100, 8'h10, 2, 0, 0, 2);
    run_dma(16'hFFFE, 8'hFF, 2, 0, 0, 1);
    run_dma(16'h3000, 8'h40, 4, 0, 40, 1);
    run_dma(16'h0500, 8'h80, 3, 2, 0, 2);
    run_dma(16'hFF00, 8'h00, 256, 0, 10, 1);

    // Randomized transfers
    for (int i = 0; i < 6; i++) begin
      run_dma(16'($urandom), 8'($urandom), int'($urandom_range(1, 6)), 1, 25,
              int'($urandom_range(1, 4)));
    end

    // Zero-length transfer completes immediately without touching the source
    base_done = done_cnt;
    @(negedge clk);
    dma_count = 9'd0;
    dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    chk("cnt0_done", 64'(dma_done), 64'd1);
    chk("cnt0_busy", 64'(dma_busy), 64'd0);
    @(negedge clk);
    chk("cnt0_once", 64'(dma_done), 64'd0);
    chk("cnt0_noreq", 64'(src_read_req), 64'd0);
    repeat (3) @(negedge clk);
    chk("cnt0_total", 64'(done_cnt - base_done), 64'd1);

    // Reset after four words with a read still in flight
    src_lat = 4;
    build_expect(16'h0200, 8'h20, 3);
    base_done = done_cnt;
    dma_seen  = 0;
    @(negedge clk);
    dma_src_address  = 16'h0200;
    dma_first_sprite = 8'h20;
    dma_count        = 9'd3;
    dma_allowed      = 1'b1;
    dma_start        = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    cyc = 0;
    while (dma_seen < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_words", 64'(dma_seen), 64'd4);
    reset_n = 1'b0;
    #1;
    dma_q.delete();
    src_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_busy", 64'(dma_busy), 64'd0);
    chk("rst_meta_we", 64'(meta_we), 64'd0);
    repeat (12) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - base_done), 64'd0);
    chk("rst_idle_busy", 64'(dma_busy), 64'd0);

    // Recovery after reset
    run_dma(16'h0A00, 8'hFE, 3, 1, 25, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
